// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sample sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fir_pkg;

    localparam int N_DEF = 16;

    // Coefficient bank addresses seen on cfg_addr
    localparam logic B0_ADDR = 1'b0;
    localparam logic B1_ADDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIRE = 2'd2,
        CAPT = 2'd3
    } seq_state_t;

endpackage

// File: rtl/fir_sample_sequencer_if.sv
// Sample stream, filter datapath and result strobe bundled between sequencer and its neighbours.
// Latency: n/a (wires only).
// Backpressure: s_ready from the sequencer holds off the sample source; results are not stallable.
// Ports: s_valid/s_ready/s_data (sample in), fir_en/fir_x/fir_b0/fir_b1/fir_y (filter), m_valid/m_data (result).
interface fir_sample_sequencer_if
    import fir_pkg::*;
#(
    parameter int N = N_DEF
);
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_data;

    logic         fir_en;
    logic [N-1:0] fir_x;
    logic [N-1:0] fir_b0;
    logic [N-1:0] fir_b1;
    logic [N-1:0] fir_y;

    logic         m_valid;
    logic [N-1:0] m_data;

    // Environment side: sample source, filter instance and result sink
    modport master (
        output s_valid, s_data, fir_y,
        input  s_ready, fir_en, fir_x, fir_b0, fir_b1, m_valid, m_data
    );

    // Sequencer side
    modport slave (
        input  s_valid, s_data, fir_y,
        output s_ready, fir_en, fir_x, fir_b0, fir_b1, m_valid, m_data
    );
endinterface

// File: rtl/sample_fifo.sv
// Small register FIFO holding samples until the sequencer issues them.
// Latency: a pushed sample is visible at head the cycle after the push.
// Backpressure: full is registered-state based; a push while full is ignored even if a pop coincides.
// Ports: push/din write, pop advances head, full/empty flags, head = oldest entry.
module sample_fifo #(
    parameter int N     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [N-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [N-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;   // power-of-2 depth: wraps naturally
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fir_sample_sequencer.sv
// Buffers samples and issues them to a 2-tap FIR at a programmable rate, with atomic coefficient commits.
// Latency: tick in cycle T -> fir_en in T+1 -> m_valid in T+2+FIR_LAT.
// Backpressure: s_ready drops while the sample FIFO is full; results are strobed without a ready.
// Ports: clk/rst_n, run/div rate control, cfg_* shadow coefficient access, status_clr,
//        bus (sample in / filter / result), underrun and commit_pend status.
module fir_sample_sequencer
    import fir_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DEPTH   = 4,
    parameter int DIV_W   = 16,
    parameter int FIR_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    input  logic             cfg_we,
    input  logic             cfg_addr,
    input  logic [N-1:0]     cfg_wdata,
    input  logic             cfg_commit,
    input  logic             status_clr,
    fir_sample_sequencer_if.slave bus,
    output logic             underrun,
    output logic             commit_pend
);
    localparam int               LAT_W   = $clog2(FIR_LAT + 1);
    // Period floor so the capture of one sample always finishes before the next tick
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(FIR_LAT + 1);

    seq_state_t       state, state_nxt;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_eff;
    logic [LAT_W-1:0] lat_cnt;
    logic             tick, lat_done, pop, starve, apply;
    logic             full, empty;
    logic [N-1:0]     head;
    logic [N-1:0]     sh_b0, sh_b1, act_b0, act_b1, x_q, y_q;
    logic             m_valid_q;

    sample_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.s_valid),
        .din   (bus.s_data),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign div_eff  = (div < DIV_MIN) ? DIV_MIN : div;
    assign tick     = (state != IDLE) && (cnt == div_eff);
    assign lat_done = (lat_cnt == LAT_W'(FIR_LAT - 1));

    assign bus.s_ready = !full;
    assign bus.fir_en  = (state == FIRE);
    assign bus.fir_x   = x_q;
    assign bus.fir_b0  = act_b0;
    assign bus.fir_b1  = act_b1;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        starve    = 1'b0;
        case (state)
            IDLE: if (run) state_nxt = WAIT;
            WAIT: begin
                if (!run) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (empty) begin
                        starve = 1'b1;
                    end else begin
                        pop       = 1'b1;
                        state_nxt = FIRE;
                    end
                end
            end
            FIRE: state_nxt = CAPT;
            CAPT: if (lat_done) state_nxt = run ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Idle commits land on the next edge; running commits wait for the edge that issues a sample
    assign apply = (state == IDLE) ? (commit_pend || cfg_commit) : (pop && commit_pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            lat_cnt     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            m_valid_q   <= 1'b0;
            sh_b0       <= '0;
            sh_b1       <= '0;
            act_b0      <= '0;
            act_b1      <= '0;
            commit_pend <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (state == IDLE || state_nxt == IDLE || tick) cnt <= '0;
            else                                            cnt <= cnt + 1'b1;

            lat_cnt <= (state == CAPT) ? lat_cnt + 1'b1 : '0;

            if (pop) x_q <= head;

            m_valid_q <= (state == CAPT) && lat_done;
            if ((state == CAPT) && lat_done) y_q <= bus.fir_y;

            if (cfg_we) begin
                if (cfg_addr == B0_ADDR)      sh_b0 <= cfg_wdata;
                else if (cfg_addr == B1_ADDR) sh_b1 <= cfg_wdata;
            end

            // Transfer reads the shadow value from before any same-cycle write
            if (apply) begin
                act_b0 <= sh_b0;
                act_b1 <= sh_b1;
            end

            if (state == IDLE) commit_pend <= 1'b0;
            else if (pop)      commit_pend <= cfg_commit;
            else               commit_pend <= commit_pend || cfg_commit;

            if (starve)          underrun <= 1'b1;
            else if (status_clr) underrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed bench for fir_sample_sequencer with a behavioural 2-tap filter (y = b0*x + b1*x_prev, 1-cycle latency).
// Latency: n/a.
// Backpressure: source honours s_ready by holding s_valid.
module tb_fir_sample_sequencer;
    import fir_pkg::*;

    localparam int N = 16;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] div;
    logic        cfg_we;
    logic        cfg_addr;
    logic [N-1:0] cfg_wdata;
    logic        cfg_commit;
    logic        status_clr;
    logic        underrun;
    logic        commit_pend;

    fir_sample_sequencer_if #(.N(N)) bus ();

    fir_sample_sequencer #(.N(N), .DEPTH(4), .DIV_W(16), .FIR_LAT(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .div         (div),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .status_clr  (status_clr),
        .bus         (bus),
        .underrun    (underrun),
        .commit_pend (commit_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in filter: result registered at the end of the fir_en cycle
    logic [N-1:0] y_mdl, xprev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_mdl <= '0;
            xprev <= '0;
        end else if (bus.fir_en) begin
            y_mdl <= bus.fir_b0 * bus.fir_x + bus.fir_b1 * xprev;
            xprev <= bus.fir_x;
        end
    end
    assign bus.fir_y = y_mdl;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int en_cyc[$], en_x[$], mv_cyc[$], mv_dat[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.fir_en) begin
                en_cyc.push_back(cyc);
                en_x.push_back(int'(bus.fir_x));
            end
            if (bus.m_valid) begin
                mv_cyc.push_back(cyc);
                mv_dat.push_back(int'(bus.m_data));
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Step to just after the next falling edge(s): inputs change and outputs are read here
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_counts(input int n_en, input int n_mv, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (en_cyc.size() >= n_en && mv_cyc.size() >= n_mv) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    initial begin
        int c0, d0, e0, mv_before;
        bit ok;
        int exp_x_a[5]   = '{2, 3, 4, 5, 6};
        int exp_y_a[5]   = '{2, 112, 160, 208, 256};
        int exp_x_b[3]   = '{8, 9, 10};
        int exp_y_b[3]   = '{352, 400, 448};

        rst_n = 1'b0; run = 1'b0; div = '0;
        cfg_we = 1'b0; cfg_addr = B0_ADDR; cfg_wdata = '0; cfg_commit = 1'b0; status_clr = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Reset state
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_fir_en", bus.fir_en, 0);
        check("rst_fir_x", bus.fir_x, 0);
        check("rst_fir_b0", bus.fir_b0, 0);
        check("rst_fir_b1", bus.fir_b1, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_underrun", underrun, 0);
        check("rst_commit_pend", commit_pend, 0);

        // Idle commit: b0=1, b1=2 applied on the edge after cfg_commit
        cfg_we = 1'b1; cfg_addr = B0_ADDR; cfg_wdata = 16'd1; step(1);
        cfg_addr = B1_ADDR; cfg_wdata = 16'd2; step(1);
        cfg_we = 1'b0; cfg_commit = 1'b1;
        check("idle_pre_commit_b0", bus.fir_b0, 0);
        step(1);
        cfg_commit = 1'b0;
        check("idle_commit_b0", bus.fir_b0, 1);
        check("idle_commit_b1", bus.fir_b1, 2);
        check("idle_commit_pend", commit_pend, 0);

        // Fill the FIFO while stopped; 5th sample is held off
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("ready_before_4th", bus.s_ready, 1);
            bus.s_valid = 1'b1; bus.s_data = 16'(2 + i);
            step(1);
        end
        bus.s_data = 16'd6;
        check("full_ready", bus.s_ready, 0);

        // Basic sequencing at div=9
        run = 1'b1; div = 16'd9; c0 = cyc;
        step(5);
        check("held_off_ready", bus.s_ready, 0);
        step(6);
        check("first_en", bus.fir_en, 1);
        check("first_x", bus.fir_x, 2);
        check("pop_ready", bus.s_ready, 1);
        step(1);
        bus.s_valid = 1'b0;
        check("refill_ready", bus.s_ready, 0);

        // Running commit: b0=16, b1=32 take effect on the next issue edge
        cfg_we = 1'b1; cfg_addr = B0_ADDR; cfg_wdata = 16'd16; step(1);
        cfg_addr = B1_ADDR; cfg_wdata = 16'd32; step(1);
        cfg_we = 1'b0; cfg_commit = 1'b1; step(1);
        cfg_commit = 1'b0;
        check("run_pend_set", commit_pend, 1);
        check("run_b0_held", bus.fir_b0, 1);
        step(5);
        check("tick_b0_old", bus.fir_b0, 1);
        check("tick_pend", commit_pend, 1);
        step(1);
        check("second_en", bus.fir_en, 1);
        check("second_x", bus.fir_x, 3);
        check("fire_b0_new", bus.fir_b0, 16);
        check("fire_b1_new", bus.fir_b1, 32);
        check("fire_pend_clr", commit_pend, 0);

        wait_counts(5, 5, 200, ok);
        check("seq_a_done", ok, 1);
        run = 1'b0;
        step(2);
        check("seq_a_underrun", underrun, 0);
        check("seq_a_ready", bus.s_ready, 1);
        check("seq_a_first_cyc", en_cyc[0] - c0, 11);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("seq_a_x%0d", i), en_x[i], exp_x_a[i]);
            check($sformatf("seq_a_y%0d", i), mv_dat[i], exp_y_a[i]);
            check($sformatf("seq_a_lat%0d", i), mv_cyc[i] - en_cyc[i], 2);
            if (i > 0) check($sformatf("seq_a_per%0d", i), en_cyc[i] - en_cyc[i-1], 10);
        end

        // Underrun with an empty FIFO at div=3
        en_cyc.delete(); en_x.delete(); mv_cyc.delete(); mv_dat.delete();
        div = 16'd3; run = 1'b1; d0 = cyc;
        step(6);
        check("underrun_set", underrun, 1);
        check("underrun_no_en", en_cyc.size(), 0);
        status_clr = 1'b1; step(1);
        status_clr = 1'b0;
        check("underrun_clr", underrun, 0);
        bus.s_valid = 1'b1; bus.s_data = 16'd7; step(1);
        bus.s_valid = 1'b0; step(1);
        check("late_en", bus.fir_en, 1);
        check("late_x", bus.fir_x, 7);
        step(2);
        check("late_m_valid", bus.m_valid, 1);
        check("late_m_data", bus.m_data, 304);
        check("late_cyc", cyc - d0, 11);
        run = 1'b0;
        step(1);
        check("late_underrun", underrun, 0);

        // Minimum divider: div=0 clamps the period to 3 cycles
        en_cyc.delete(); en_x.delete(); mv_cyc.delete(); mv_dat.delete();
        div = 16'd0;
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1; bus.s_data = 16'(8 + i); step(1);
        end
        bus.s_valid = 1'b0;
        run = 1'b1; e0 = cyc;
        wait_counts(3, 3, 100, ok);
        run = 1'b0;
        check("seq_b_done", ok, 1);
        step(2);
        check("seq_b_underrun", underrun, 0);
        check("seq_b_first_cyc", en_cyc[0] - e0, 4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("seq_b_x%0d", i), en_x[i], exp_x_b[i]);
            check($sformatf("seq_b_y%0d", i), mv_dat[i], exp_y_b[i]);
            check($sformatf("seq_b_lat%0d", i), mv_cyc[i] - en_cyc[i], 2);
            if (i > 0) check($sformatf("seq_b_per%0d", i), en_cyc[i] - en_cyc[i-1], 3);
        end

        // Reset in the cycle after fir_en drops the in-flight result
        div = 16'd3;
        bus.s_valid = 1'b1; bus.s_data = 16'd11; step(1);
        bus.s_valid = 1'b0;
        run = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (bus.fir_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("midrst_en_seen", ok, 1);
        mv_before = mv_cyc.size();
        step(1);
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        check("midrst_fir_b0", bus.fir_b0, 0);
        step(4);
        check("midrst_no_mvalid", mv_cyc.size(), mv_before);
        check("midrst_m_valid", bus.m_valid, 0);
        rst_n = 1'b1;
        step(2);
        check("midrst_m_valid_after", bus.m_valid, 0);
        check("midrst_ready", bus.s_ready, 1);
        check("midrst_pend", commit_pend, 0);
        check("midrst_b1", bus.fir_b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fir_sample_sequencer.md
# fir_sample_sequencer

Sequences the shared 2-tap FIR datapath (`optFIR_Filter`: x, b0, b1, en, y). It buffers incoming samples in a small FIFO and issues them to the filter at a programmable sample rate by pulsing the filter enable. It applies coefficient updates atomically at sample boundaries and captures each filter result into a valid-qualified output. It sits between the sample source / register interface and the filter instance.

## Interface
Parameters:
- `N`, 16, sample and coefficient width.
- `DEPTH`, 4, input FIFO depth; power of 2, ≥2.
- `DIV_W`, 16, width of the sample-period divider.
- `FIR_LAT`, 1, cycles from the `fir_en` cycle until `fir_y` holds the new result; ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: enables sample sequencing.
- `div` in DIV_W: sample period minus 1, in clk cycles.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: FIFO not full.
- `s_data` in N: input sample.
- `cfg_we` in 1: shadow coefficient write strobe.
- `cfg_addr` in 1: 0 selects b0, 1 selects b1.
- `cfg_wdata` in N: shadow write data.
- `cfg_commit` in 1: request transfer of shadow coefficients to active.
- `status_clr` in 1: clears `underrun`.
- `fir_en` out 1: filter enable, one-cycle pulse.
- `fir_x` out N: sample presented to the filter.
- `fir_b0`, `fir_b1` out N: active coefficients.
- `fir_y` in N: filter output.
- `m_valid` out 1: one-cycle result strobe.
- `m_data` out N: captured filter result.
- `underrun` out 1: sticky; set when a tick found the FIFO empty.
- `commit_pend` out 1: a commit is waiting for the next tick.

## Operation
- **Reset values.** All outputs are 0 except `s_ready`=1. The FIFO is empty. The divider count is 0. The FSM is in IDLE. Shadow and active coefficients are 0.
- **FIFO.**
  - Push when `s_valid && s_ready`.
  - `s_ready` = !full, registered-state based.
  - A push while full is impossible, because `s_ready` is 0 even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
  - Count width is log2(DEPTH)+1.
- **Divider.**
  - Runs only when the FSM is not IDLE.
  - `cnt` counts 0..`div_eff`, then wraps to 0.
  - tick = (`cnt`==`div_eff`).
  - `div_eff` = max(`div`, FIR_LAT+1), so a capture always completes before the next tick.
  - `div` is sampled continuously; a change takes effect on the next comparison.
- **FSM states.**
  - IDLE → WAIT when `run`=1. `cnt` is cleared.
  - WAIT → FIRE on tick if the FIFO is not empty. At that edge: pop the FIFO, load `fir_x` with the head, and apply the pending commit.
  - WAIT stays in WAIT on tick if the FIFO is empty. `underrun` is set and `fir_en` stays 0.
  - FIRE: `fir_en`=1 for exactly this cycle, then → CAPT.
  - CAPT: waits until FIR_LAT cycles have elapsed since the FIRE cycle. It registers `m_data`←`fir_y` and pulses `m_valid`, then → WAIT, or → IDLE if `run`=0.
  - `run`=0 in WAIT → IDLE, and `cnt` is cleared.
  - `run`=0 in FIRE or CAPT: the in-flight sample completes, then → IDLE.
  - The FIFO contents are kept across IDLE.
- **Coefficients.**
  - `cfg_we` writes the shadow register selected by `cfg_addr`.
  - `cfg_commit` sets `commit_pend`.
  - On the next tick that pops a sample, active←shadow and `commit_pend` clears, on the same edge that enters FIRE. The issued sample therefore uses the new coefficients.
  - `cfg_commit` in the same cycle as that transfer keeps `commit_pend`=1.
  - `cfg_we` in the same cycle as the transfer: the transfer uses the old shadow value.
  - In IDLE, a commit is applied immediately on the following edge.
- **Status.** If `status_clr` and an underrun set occur in the same cycle, set wins.
- **Reset mid-operation.** Asserting `rst_n` low asynchronously returns every register to its reset value. The in-flight sample is dropped and `m_valid` is not asserted.

## Timing
- Tick in cycle T → `fir_en`=1 in cycle T+1.
- `fir_y` is captured at the edge ending cycle T+1+FIR_LAT.
- `m_valid`=1 in cycle T+2+FIR_LAT.
- Steady state: one `fir_en` every `div_eff`+1 cycles.
- The first tick occurs `div_eff`+1 cycles after leaving IDLE.
- `s_ready` deasserts the cycle after the push that fills the FIFO.

## Structure
- Shared package `fir_pkg`: FSM state enum (IDLE, WAIT, FIRE, CAPT), default `N`, coefficient address constants (`B0_ADDR`=0, `B1_ADDR`=1).
- One sub-module: `sample_fifo` (parameterised N/DEPTH; push, pop, full, empty, head). Divider, FSM and coefficient bank stay in the top level.

## Test plan
1. **Reset.** Release `rst_n` → all outputs 0, `s_ready`=1. Assert `rst_n` low in the cycle after `fir_en` → no `m_valid` follows.
2. **Basic sequencing.** `div`=9, push samples 2,3,4,5, `run`=1 → `fir_en` pulses exactly 10 cycles apart with `fir_x`=2,3,4,5. Each `m_valid` comes FIR_LAT+1 cycles after its `fir_en` with `m_data`=`fir_y` at capture.
3. **Full FIFO.** Push 5 samples with `run`=0, DEPTH=4 → `s_ready`=0 after the 4th push, and the 5th sample is held off. One pop → `s_ready`=1.
4. **Underrun.** `run`=1 with an empty FIFO, `div`=3 → no `fir_en`, `underrun`=1. `status_clr` → 0. Push 1 sample → issued at the next tick.
5. **Coefficient commit.** Write b0=16, b1=32 to shadow, commit while running → active b0/b1 change exactly on the `fir_en` edge, and `commit_pend` drops then. Commit in IDLE → active updates the next cycle.
6. **Minimum divider.** `div`=0, FIR_LAT=1 → period clamps to 3 cycles, and no tick overlaps CAPT.
